if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, issues req/ack reads to instruction memory, and writes the IF/ID register.
//  Drives the IF/ID write-enable (le), instruction and PC+4 inputs.
//  Honours stall from the hazard unit and redirect (taken branch/jump) from later stages.
//  Buffers one fetched word while stalled, so no memory read is lost or repeated.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  NOP_INSTR  32'h0000_0000  word written into IF/ID to squash a wrong-path instruction (sll $0,$0,0)
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  reset         in   1   synchronous, active-high
//  stall         in   1   ID cannot accept a new instruction this cycle
//  redirect      in   1   taken branch/jump this cycle
//  redirect_pc   in   32  target address; bits [1:0] are ignored and forced to 0
//  imem_req      out  1   read request to instruction memory
//  imem_addr     out  32  read address; stable while imem_req=1 and no ack
//  imem_ack      in   1   read data valid this cycle; ends the request
//  imem_rdata    in   32  instruction word, valid with imem_ack
//  le            out  1   IF/ID write-enable
//  instruccion   out  32  IF/ID instruction input
//  pc4           out  32  IF/ID PC+4 input
//  fetch_count   out  32  count of instructions delivered with le=1 (NOP squashes excluded); wraps
// BEHAVIOUR
//  Reset (sync): state=S_REQ, pc=RESET_PC, buf=0, fetch_count=0.
//   - Any outstanding memory read is abandoned; imem must be reset by the same reset.
//  FSM states: S_REQ, S_HOLD, S_FLUSH. All outputs below are combinational from state, pc, buf and inputs.
//  S_REQ (imem_req=1, imem_addr=pc):
//   - redirect: le=1, instruccion=NOP_INSTR, pc4=0.
//     - ack in the same cycle: drop rdata, pc<=redirect_pc, stay in S_REQ.
//     - no ack: tgt<=redirect_pc, go to S_FLUSH.
//   - else ack & !stall: le=1, instruccion=imem_rdata, pc4=pc+4, pc<=pc+4, fetch_count++.
//   - else ack & stall: le=0, buf<=imem_rdata, go to S_HOLD.
//   - else: le=0, wait in S_REQ.
//  S_HOLD (imem_req=0):
//   - redirect: le=1 with NOP_INSTR, pc<=redirect_pc, go to S_REQ.
//   - else !stall: le=1, instruccion=buf, pc4=pc+4, pc<=pc+4, fetch_count++, go to S_REQ.
//   - else: le=0, stay in S_HOLD.
//  S_FLUSH (imem_req=1, imem_addr=pc, i.e. the old address kept until ack):
//   - le=0.
//   - redirect: tgt<=redirect_pc (latest target wins).
//   - ack: discard rdata, pc<=(redirect ? redirect_pc : tgt), go to S_REQ.
//  Priorities and timing:
//   - Priority: reset > redirect > stall.
//   - Redirect squashes the IF/ID content even when stall=1.
//   - Fetch latency: one instruction delivered per cycle at best (ack every cycle, no stall), with zero-cycle path from ack to le.
//  Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC + 4 -> 0); fetch_count wraps 32'hFFFF_FFFF -> 0.
//  When le=0, instruccion/pc4 are don't-care but must be X-free (drive buf and pc+4).
//  Memory request rule: imem_req never drops and imem_addr never changes while a request is un-acked.
// STRUCTURE
//  Shared package mips_pkg: NOP_INSTR, RESET_PC, the fetch state enum (S_REQ/S_HOLD/S_FLUSH), width WORD_W=32.
//  No sub-module: PC register, buf, tgt, counter and FSM live in a single file.
// TESTING
//  1. Streaming: reset, then ack every cycle with rdata=0x20080001..; le=1 every cycle from the first ack.
//     - pc4 sequence is 4, 8, 12...; fetch_count=N after N acks.
//  2. Stall: ack arrives at pc=0x8 while stall=1 for 3 cycles; le=0 and imem_req=0 during the stall.
//     - First cycle after stall: le=1, instruccion=buffered word, pc4=0xC; next request is to 0xC (no re-read of 0x8).
//  3. Redirect, no ack: redirect=1, redirect_pc=0x400 while the request to 0x10 is pending; le=1 with NOP_INSTR.
//     - imem_addr stays 0x10 until ack; that data is dropped; next imem_addr=0x400.
//  4. Redirect + stall in S_HOLD: redirect_pc=0x203 -> le=1 with NOP; next imem_addr=0x200; fetch_count unchanged.
//  5. Wrap: RESET_PC=0xFFFF_FFFC, one ack -> pc4=0, next imem_addr=0.
//  6. Reset mid-operation: assert reset in S_FLUSH -> next cycle state S_REQ, imem_addr=RESET_PC, fetch_count=0, tgt ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: word width, reset/NOP
// constants and the fetch-stage state encoding.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read bus. req/addr are held until ack; ack ends the read
// and qualifies rdata in the same cycle.
interface if_fetch_unit_if;
  import mips_pkg::*;
  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory and feeds the IF/ID
// register, with a one-word buffer for stalls and a flush state for redirects.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [WORD_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [WORD_W-1:0]  redirect_pc,
  if_fetch_unit_if.master    imem,
  output logic               le,
  output logic [WORD_W-1:0]  instruccion,
  output logic [WORD_W-1:0]  pc4,
  output logic [WORD_W-1:0]  fetch_count,
  output fetch_state_e       state_dbg
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [WORD_W-1:0] tgt_q, tgt_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] rpc_aligned;

  assign pc_plus4    = pc_q + 32'd4;
  assign rpc_aligned = word_align(redirect_pc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    buf_d          = buf_q;
    tgt_d          = tgt_q;
    cnt_d          = cnt_q;
    le             = 1'b0;
    instruccion    = buf_q;
    pc4            = pc_plus4;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;

    unique case (state_q)
      S_REQ: begin
        imem.imem_req = 1'b1;
        if (redirect) begin
          le          = 1'b1;
          instruccion = NOP_INSTR;
          pc4         = '0;
          if (imem.imem_ack) begin
            pc_d = rpc_aligned;
          end else begin
            tgt_d   = rpc_aligned;
            state_d = S_FLUSH;
          end
        end else if (imem.imem_ack && !stall) begin
          le          = 1'b1;
          instruccion = imem.imem_rdata;
          pc_d        = pc_plus4;
          cnt_d       = cnt_q + 32'd1;
        end else if (imem.imem_ack) begin
          buf_d   = imem.imem_rdata;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          le          = 1'b1;
          instruccion = NOP_INSTR;
          pc4         = '0;
          pc_d        = rpc_aligned;
          state_d     = S_REQ;
        end else if (!stall) begin
          le      = 1'b1;
          pc_d    = pc_plus4;
          cnt_d   = cnt_q + 32'd1;
          state_d = S_REQ;
        end
      end

      S_FLUSH: begin
        // The wrong-path read must still complete at its original address.
        imem.imem_req = 1'b1;
        if (redirect) tgt_d = rpc_aligned;
        if (imem.imem_ack) begin
          pc_d    = redirect ? rpc_aligned : tgt_q;
          state_d = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  assign fetch_count = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized
// run against a flag-based behavioural model of the fetch stage.
module tb_if_fetch_unit;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        le, w_le;
  logic [31:0] instr, w_instr, pc4, w_pc4, fcnt, w_fcnt;
  fetch_state_e st, w_st;

  int n_vec = 0;
  int n_err = 0;

  if_fetch_unit_if bus();
  if_fetch_unit_if wbus();

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(bus), .le(le), .instruccion(instr),
    .pc4(pc4), .fetch_count(fcnt), .state_dbg(st)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(wbus), .le(w_le), .instruccion(w_instr),
    .pc4(w_pc4), .fetch_count(w_fcnt), .state_dbg(w_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: what the stage owes the pipeline, tracked as flags.
  logic [31:0] m_pc, m_buf, m_tgt, m_cnt;
  logic        m_have_buf, m_drop_next;

  task automatic model_reset(input logic [31:0] rp);
    m_pc = rp; m_buf = 0; m_tgt = 0; m_cnt = 0; m_have_buf = 0; m_drop_next = 0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [31:0] rpc,
                            input logic a, input logic [31:0] d);
    logic [31:0] t;
    t = {rpc[31:2], 2'b00};
    if (m_drop_next) begin
      if (r) m_tgt = t;
      if (a) begin m_pc = r ? t : m_tgt; m_drop_next = 0; end
    end else if (r) begin
      if (m_have_buf)  begin m_have_buf = 0; m_pc = t; end
      else if (a)      m_pc = t;
      else             begin m_drop_next = 1; m_tgt = t; end
    end else if (m_have_buf) begin
      if (!s) begin m_have_buf = 0; m_pc = m_pc + 4; m_cnt = m_cnt + 1; end
    end else if (a) begin
      if (s) begin m_have_buf = 1; m_buf = d; end
      else   begin m_pc = m_pc + 4; m_cnt = m_cnt + 1; end
    end
  endtask

  task automatic set_in(input logic s, input logic r, input logic [31:0] rpc,
                        input logic a, input logic [31:0] d);
    stall = s; redirect = r; redirect_pc = rpc;
    bus.imem_ack = a; bus.imem_rdata = d;
    @(negedge clk);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    wbus.imem_ack = 1'b0; wbus.imem_rdata = 32'h0;
    set_in(0, 0, 0, 0, 0);
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge clk);
    n_vec++; if (st !== S_REQ) begin n_err++; $display("FAIL reset_state: got %0d want %0d", st, S_REQ); end
    n_vec++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL reset_req: got %b want 1", bus.imem_req); end
    n_vec++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    n_vec++; if (le !== 1'b0) begin n_err++; $display("FAIL reset_le: got %b want 0", le); end
    n_vec++; if (fcnt !== 32'h0) begin n_err++; $display("FAIL reset_count: got %h want 0", fcnt); end
    n_vec++; if (wbus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL reset_addr_w: got %h want fffffffc", wbus.imem_addr); end
    tick;
  endtask

  task automatic test_streaming;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 1, 32'h2008_0001 + i);
      n_vec++; if (le !== 1'b1) begin n_err++; $display("FAIL stream_le[%0d]: got %b want 1", i, le); end
      n_vec++; if (instr !== 32'h2008_0001 + i) begin n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr, 32'h2008_0001 + i); end
      n_vec++; if (pc4 !== 4 * (i + 1)) begin n_err++; $display("FAIL stream_pc4[%0d]: got %h want %h", i, pc4, 4 * (i + 1)); end
      n_vec++; if (bus.imem_addr !== 4 * i) begin n_err++; $display("FAIL stream_addr[%0d]: got %h want %h", i, bus.imem_addr, 4 * i); end
      tick;
      n_vec++; if (fcnt !== i + 1) begin n_err++; $display("FAIL stream_count[%0d]: got %0d want %0d", i, fcnt, i + 1); end
    end
  endtask

  task automatic test_stall;
    do_reset;
    set_in(0, 0, 0, 1, 32'h1111_0000); tick;
    set_in(0, 0, 0, 1, 32'h1111_0004); tick;
    set_in(1, 0, 0, 1, 32'hCAFE_0008);
    n_vec++; if (bus.imem_addr !== 32'h8) begin n_err++; $display("FAIL stall_addr: got %h want 8", bus.imem_addr); end
    n_vec++; if (le !== 1'b0) begin n_err++; $display("FAIL stall_le_ack: got %b want 0", le); end
    tick;
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0, 0, 32'h0);
      n_vec++; if (le !== 1'b0) begin n_err++; $display("FAIL stall_le[%0d]: got %b want 0", i, le); end
      n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d]: got %b want 0", i, bus.imem_req); end
      tick;
    end
    set_in(0, 0, 0, 0, 32'h0);
    n_vec++; if (le !== 1'b1) begin n_err++; $display("FAIL unstall_le: got %b want 1", le); end
    n_vec++; if (instr !== 32'hCAFE_0008) begin n_err++; $display("FAIL unstall_instr: got %h want cafe0008", instr); end
    n_vec++; if (pc4 !== 32'hC) begin n_err++; $display("FAIL unstall_pc4: got %h want c", pc4); end
    tick;
    @(negedge clk);
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin n_err++; $display("FAIL unstall_next: got req=%b addr=%h want req=1 addr=c", bus.imem_req, bus.imem_addr); end
    n_vec++; if (fcnt !== 32'd3) begin n_err++; $display("FAIL unstall_count: got %0d want 3", fcnt); end
    tick;
  endtask

  task automatic test_redirect_no_ack;
    do_reset;
    for (int i = 0; i < 4; i++) begin set_in(0, 0, 0, 1, 32'h100 + i); tick; end
    set_in(0, 1, 32'h400, 0, 0);
    n_vec++; if (le !== 1'b1 || instr !== NOP_INSTR) begin n_err++; $display("FAIL redir_nop: got le=%b instr=%h want le=1 instr=%h", le, instr, NOP_INSTR); end
    n_vec++; if (bus.imem_addr !== 32'h10) begin n_err++; $display("FAIL redir_addr0: got %h want 10", bus.imem_addr); end
    tick;
    set_in(0, 0, 0, 0, 0);
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin n_err++; $display("FAIL redir_hold_addr: got req=%b addr=%h want req=1 addr=10", bus.imem_req, bus.imem_addr); end
    tick;
    set_in(0, 0, 0, 1, 32'hDEAD_BEEF);
    n_vec++; if (le !== 1'b0) begin n_err++; $display("FAIL redir_drop: got le=%b want 0", le); end
    tick;
    set_in(0, 0, 0, 0, 0);
    n_vec++; if (bus.imem_addr !== 32'h400) begin n_err++; $display("FAIL redir_target: got %h want 400", bus.imem_addr); end
    n_vec++; if (fcnt !== 32'd4) begin n_err++; $display("FAIL redir_count: got %0d want 4", fcnt); end
    tick;
  endtask

  task automatic test_redirect_hold;
    do_reset;
    set_in(1, 0, 0, 1, 32'h1234_5678); tick;
    set_in(1, 1, 32'h203, 0, 0);
    n_vec++; if (le !== 1'b1 || instr !== NOP_INSTR) begin n_err++; $display("FAIL hold_redir_nop: got le=%b instr=%h want le=1 instr=%h", le, instr, NOP_INSTR); end
    tick;
    set_in(0, 0, 0, 0, 0);
    n_vec++; if (bus.imem_addr !== 32'h200 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL hold_redir_addr: got req=%b addr=%h want req=1 addr=200", bus.imem_req, bus.imem_addr); end
    n_vec++; if (fcnt !== 32'd0) begin n_err++; $display("FAIL hold_redir_count: got %0d want 0", fcnt); end
    tick;
  endtask

  task automatic test_wrap;
    do_reset;
    wbus.imem_ack = 1'b1; wbus.imem_rdata = 32'h0BAD_F00D;
    set_in(0, 0, 0, 0, 0);
    n_vec++; if (w_le !== 1'b1 || w_pc4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got le=%b pc4=%h want le=1 pc4=0", w_le, w_pc4); end
    tick;
    wbus.imem_ack = 1'b0;
    @(negedge clk);
    n_vec++; if (wbus.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", wbus.imem_addr); end
    n_vec++; if (w_fcnt !== 32'd1) begin n_err++; $display("FAIL wrap_count: got %0d want 1", w_fcnt); end
    tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    set_in(0, 0, 0, 1, 32'h1); tick;
    set_in(0, 1, 32'h800, 0, 0); tick;
    @(negedge clk);
    n_vec++; if (st !== S_FLUSH) begin n_err++; $display("FAIL mid_flush_state: got %0d want %0d", st, S_FLUSH); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0);
    n_vec++; if (st !== S_REQ || bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL mid_reset: got state=%0d addr=%h want state=%0d addr=0", st, bus.imem_addr, S_REQ); end
    n_vec++; if (fcnt !== 32'd0) begin n_err++; $display("FAIL mid_reset_count: got %0d want 0", fcnt); end
    tick;
    set_in(0, 0, 0, 1, 32'h77);
    n_vec++; if (le !== 1'b1 || pc4 !== 32'h4) begin n_err++; $display("FAIL mid_first: got le=%b pc4=%h want le=1 pc4=4", le, pc4); end
    tick;
    @(negedge clk);
    n_vec++; if (bus.imem_addr !== 32'h4) begin n_err++; $display("FAIL mid_tgt_ignored: got %h want 4", bus.imem_addr); end
    tick;
  endtask

  task automatic test_random;
    logic s, r, a, e_req, e_le, real_word, prev_pending;
    logic [31:0] rpc, d, e_instr, prev_addr;
    do_reset;
    model_reset(32'h0);
    prev_pending = 0; prev_addr = 0;
    for (int c = 0; c < 600; c++) begin
      s   = ($urandom_range(0, 99) < 30);
      r   = ($urandom_range(0, 99) < 10);
      rpc = $urandom;
      d   = $urandom;
      e_req = !m_have_buf;
      a   = e_req && ($urandom_range(0, 99) < 60);
      real_word = 0; e_instr = 0;
      if (m_drop_next)     e_le = 0;
      else if (r)          begin e_le = 1; e_instr = NOP_INSTR; end
      else if (m_have_buf) begin e_le = !s; e_instr = m_buf; real_word = 1; end
      else                 begin e_le = a && !s; e_instr = d; real_word = 1; end
      set_in(s, r, rpc, a, d);
      n_vec++; if (bus.imem_req !== e_req || bus.imem_addr !== m_pc) begin n_err++; $display("FAIL rnd_bus[%0d]: got req=%b addr=%h want req=%b addr=%h", c, bus.imem_req, bus.imem_addr, e_req, m_pc); end
      n_vec++; if (le !== e_le) begin n_err++; $display("FAIL rnd_le[%0d]: got %b want %b", c, le, e_le); end
      if (e_le) begin
        n_vec++; if (instr !== e_instr) begin n_err++; $display("FAIL rnd_instr[%0d]: got %h want %h", c, instr, e_instr); end
        if (real_word) begin
          n_vec++; if (pc4 !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_pc4[%0d]: got %h want %h", c, pc4, m_pc + 32'd4); end
        end
      end
      if (prev_pending) begin
        n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin n_err++; $display("FAIL rnd_req_rule[%0d]: got req=%b addr=%h want req=1 addr=%h", c, bus.imem_req, bus.imem_addr, prev_addr); end
      end
      prev_pending = bus.imem_req && !a;
      prev_addr    = bus.imem_addr;
      model_step(s, r, rpc, a, d);
      tick;
      n_vec++; if (fcnt !== m_cnt) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, fcnt, m_cnt); end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset;
    test_streaming;
    test_stall;
    test_redirect_no_ack;
    test_redirect_hold;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
